// File: rtl/instr_decode.sv
// instr_decode: E-stage instruction decoder for the pipelined MIPS-I CPU.
// Turns a 32-bit instruction word into an ALU operation, a mult/div
// operation with its launch pulse, an overflow-trap enable and a
// reserved-instruction flag. Decode is purely combinational; the only
// state is a reset mask that forces NOP decode while reset is held.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [3:0]  ALUOp,
    output logic [3:0]  MDOp,
    output logic        start,
    output logic        ov_chk,
    output logic        ri
);

    // ALU operation codes; 14 is intentionally unused.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLLV = 4'd9,
        ALU_SRLV = 4'd10,
        ALU_SRAV = 4'd11,
        ALU_SLT  = 4'd12,
        ALU_SLTU = 4'd13,
        ALU_NONE = 4'd15
    } alu_op_e;

    // Mult/div unit operation codes.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // Instruction fields that take part in decode.
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign funct = instr[5:0];

    // rs, rd, shamt and the immediate field are consumed by other stages.
    logic unused_fields;
    assign unused_fields = ^{instr[25:21], instr[15:6]};

    // Reset mask: comes up set so outputs are NOP before the first edge,
    // and stays set until the first edge with reset released.
    logic rmask = 1'b1;

    // Track reset synchronously; rmask is the only storage in the block.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create ordering-dependent races.
        if (!reset) rmask <= 1'b1;
        else        rmask <= 1'b0;
    end

    alu_op_e alu_dec;
    md_op_e  md_dec;
    logic    ov_dec;
    logic    ri_dec;

    // Decode op/funct/rt into the raw (unmasked) control fields.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statements leaves a value held (no latches).
        alu_dec = ALU_NONE;
        md_dec  = MD_NONE;
        ov_dec  = 1'b0;
        ri_dec  = 1'b0;

        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: begin alu_dec = ALU_ADD; ov_dec = 1'b1; end
                    6'b100001: alu_dec = ALU_ADD;
                    6'b100010: begin alu_dec = ALU_SUB; ov_dec = 1'b1; end
                    6'b100011: alu_dec = ALU_SUB;
                    6'b100100: alu_dec = ALU_AND;
                    6'b100101: alu_dec = ALU_OR;
                    6'b100110: alu_dec = ALU_XOR;
                    6'b100111: alu_dec = ALU_NOR;
                    6'b101010: alu_dec = ALU_SLT;
                    6'b101011: alu_dec = ALU_SLTU;
                    6'b000000: alu_dec = ALU_SLL;
                    6'b000010: alu_dec = ALU_SRL;
                    6'b000011: alu_dec = ALU_SRA;
                    6'b000100: alu_dec = ALU_SLLV;
                    6'b000110: alu_dec = ALU_SRLV;
                    6'b000111: alu_dec = ALU_SRAV;
                    6'b011000: md_dec  = MD_MULT;
                    6'b011001: md_dec  = MD_MULTU;
                    6'b011010: md_dec  = MD_DIV;
                    6'b011011: md_dec  = MD_DIVU;
                    6'b010000: md_dec  = MD_MFHI;
                    6'b010001: md_dec  = MD_MTHI;
                    6'b010010: md_dec  = MD_MFLO;
                    6'b010011: md_dec  = MD_MTLO;
                    6'b001000,
                    6'b001001,
                    6'b001100: ; // jr, jalr, syscall: no ALU work
                    default:   ri_dec = 1'b1;
                endcase
            end
            6'b001000: begin alu_dec = ALU_ADD; ov_dec = 1'b1; end
            6'b001001: alu_dec = ALU_ADD;
            6'b001010: alu_dec = ALU_SLT;
            6'b001011: alu_dec = ALU_SLTU;
            6'b001100: alu_dec = ALU_AND;
            6'b001101: alu_dec = ALU_OR;
            6'b001110: alu_dec = ALU_XOR;
            6'b001111: alu_dec = ALU_OR;  // lui: ALU passes the shifted immediate
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
            6'b101000, 6'b101001, 6'b101011:
                alu_dec = ALU_ADD;        // loads/stores: address = base + offset
            6'b000100, 6'b000101, 6'b000110, 6'b000111,
            6'b000010, 6'b000011, 6'b010000:
                ;                         // branches, jumps, cop0: no ALU work
            6'b000001: begin
                // regimm: only bltz/bgez are implemented
                if (rt != 5'b00000 && rt != 5'b00001) ri_dec = 1'b1;
            end
            default: ri_dec = 1'b1;
        endcase
    end

    // While masked the decoder presents a NOP regardless of instr.
    assign ALUOp  = rmask ? ALU_NONE : alu_dec;
    assign MDOp   = rmask ? MD_NONE  : md_dec;
    assign start  = !rmask && (md_dec inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    assign ov_chk = !rmask && ov_dec;
    assign ri     = !rmask && ri_dec;

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed-vector bench for instr_decode. Expected values
// are hand-derived from the MIPS-I opcode/funct encodings.
module tb_instr_decode;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  ALUOp;
    logic [3:0]  MDOp;
    logic        start;
    logic        ov_chk;
    logic        ri;

    int checks;
    int errors;

    instr_decode dut (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .ALUOp  (ALUOp),
        .MDOp   (MDOp),
        .start  (start),
        .ov_chk (ov_chk),
        .ri     (ri)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one instruction away from the clock edge and check every output.
    task automatic run_vec(input string tag, input logic [31:0] w,
                           input logic [3:0] e_alu, input logic [3:0] e_md,
                           input logic e_start, input logic e_ov, input logic e_ri);
        @(negedge clk);
        instr = w;
        #1;
        check({tag, ".alu"},   {28'd0, ALUOp}, {28'd0, e_alu});
        check({tag, ".md"},    {28'd0, MDOp},  {28'd0, e_md});
        check({tag, ".start"}, {31'd0, start}, {31'd0, e_start});
        check({tag, ".ov"},    {31'd0, ov_chk}, {31'd0, e_ov});
        check({tag, ".ri"},    {31'd0, ri},    {31'd0, e_ri});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        instr  = 32'h0085_1020;              // add $2,$4,$5

        // Masked before any edge and through two reset edges.
        #1;
        check("pre_edge.alu", {28'd0, ALUOp}, 32'd15);
        repeat (2) @(posedge clk);
        #1;
        check("rst.alu", {28'd0, ALUOp}, 32'd15);
        check("rst.ov",  {31'd0, ov_chk}, 32'd0);
        check("rst.ri",  {31'd0, ri},     32'd0);

        // Release reset; mask must hold until the next edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_pre.alu", {28'd0, ALUOp}, 32'd15);
        @(posedge clk);
        #1;
        check("release.alu", {28'd0, ALUOp}, 32'd0);
        check("release.ov",  {31'd0, ov_chk}, 32'd1);
        check("release.ri",  {31'd0, ri},     32'd0);

        //        tag        instr          alu    md    st    ov    ri
        run_vec("add",     32'h0085_1020, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0);
        run_vec("addu",    32'h0085_1021, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sub",     32'h0085_1022, 4'd1,  4'd0, 1'b0, 1'b1, 1'b0);
        run_vec("subu",    32'h0085_1023, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("and",     32'h0085_1024, 4'd3,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("or",      32'h0085_1025, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("xor",     32'h0085_1026, 4'd4,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("nor",     32'h0085_1027, 4'd5,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("slt",     32'h0085_102A, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sltu",    32'h0085_102B, 4'd13, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sll",     32'h0004_1080, 4'd6,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("srl",     32'h0004_1082, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sra",     32'h0004_1083, 4'd8,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sllv",    32'h00A4_1004, 4'd9,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("srlv",    32'h00A4_1006, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("srav",    32'h00A4_1007, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("nop",     32'h0000_0000, 4'd6,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("mult",    32'h0085_0018, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0);
        run_vec("multu",   32'h0085_0019, 4'd15, 4'd2, 1'b1, 1'b0, 1'b0);
        run_vec("div",     32'h0085_001A, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0);
        run_vec("divu",    32'h0085_001B, 4'd15, 4'd4, 1'b1, 1'b0, 1'b0);
        run_vec("mthi",    32'h0200_0011, 4'd15, 4'd5, 1'b0, 1'b0, 1'b0);
        run_vec("mtlo",    32'h0200_0013, 4'd15, 4'd6, 1'b0, 1'b0, 1'b0);
        run_vec("mfhi",    32'h0000_1010, 4'd15, 4'd7, 1'b0, 1'b0, 1'b0);
        run_vec("mflo",    32'h0000_1012, 4'd15, 4'd8, 1'b0, 1'b0, 1'b0);
        run_vec("jr",      32'h03E0_0008, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("jalr",    32'h0080_F809, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("syscall", 32'h0000_000C, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("addi",    32'h2082_0005, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0);
        run_vec("addiu",   32'h2482_0005, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("slti",    32'h2882_000A, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sltiu",   32'h2C82_000A, 4'd13, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("andi",    32'h3082_000F, 4'd3,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("ori",     32'h34A4_FFFF, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("xori",    32'h3882_000F, 4'd4,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("lui",     32'h3C01_1234, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("lb",      32'h8082_0004, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("lhu",     32'h9482_0004, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("lw",      32'h8C82_0004, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sb",      32'hA082_0000, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("sw",      32'hAC82_0000, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("beq",     32'h1085_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("bne",     32'h1485_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("blez",    32'h1880_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("bgtz",    32'h1C80_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("bltz",    32'h0480_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("bgez",    32'h0481_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("j",       32'h0800_0010, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("jal",     32'h0C00_0010, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("mfc0",    32'h4002_6000, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        run_vec("ri_op3f", 32'hFC00_0000, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        run_vec("ri_fn3f", 32'h0000_003F, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        run_vec("ri_fn01", 32'h0000_0001, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        run_vec("ri_fn05", 32'h0000_0005, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        run_vec("ri_rt02", 32'h0482_0003, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        run_vec("ri_cop1", 32'h4400_0000, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);

        // Re-assert reset mid-run: decode stays live until the edge, then masks.
        @(negedge clk);
        instr = 32'h0085_0018;               // mult
        reset = 1'b0;
        #1;
        check("reassert_pre.start", {31'd0, start}, 32'd1);
        @(posedge clk);
        #1;
        check("reassert.start", {31'd0, start}, 32'd0);
        check("reassert.md",    {28'd0, MDOp},  32'd0);
        check("reassert.alu",   {28'd0, ALUOp}, 32'd15);
        instr = 32'hFC00_0000;               // reserved op while masked
        #1;
        check("reassert.ri",    {31'd0, ri},    32'd0);

        // Release again and confirm decode resumes.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease.ri",   {31'd0, ri},    32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
